instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the 9-bit accumulator processor. It holds the program counter and issues addresses to the synchronous instruction ROM. It registers the returned machine code into an instruction register that drives the control decoder's `Instruction` input. It also accepts jump redirects and halt indications decoded from that instruction, and supports downstream stall.

## Interface
Parameters:
- `PC_W`, 10, program counter / ROM address width
- `INSTR_W`, 9, instruction width

Ports:
- `CLK` in 1: single clock, all state on rising edge
- `Reset_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse; begins execution at `start_addr` (honoured in IDLE/DONE only)
- `start_addr` in PC_W: first fetch address
- `stall` in 1: downstream not ready; hold `Instruction`/`instr_valid`
- `redirect` in 1: taken jump for the instruction currently in IR (from decoder `jump_en` plus branch resolution)
- `target` in PC_W: absolute redirect address
- `halt` in 1: instruction currently in IR is the halt instruction
- `imem_addr` out PC_W: ROM read address (ROM returns data one cycle later)
- `imem_rdata` in INSTR_W: ROM read data
- `Instruction` out INSTR_W: instruction register (IR) contents
- `instr_valid` out 1: IR holds a live instruction
- `instr_pc` out PC_W: address of the instruction in IR
- `done` out 1: high in DONE state

## Operation
- States: IDLE, RUN, DONE. Registers: `fpc` (next fetch address), `req_v`/`req_pc` (ROM request in flight), IR plus `ir_v`/`ir_pc`.
- `imem_addr` = `stall` ? `req_pc` : `fpc` (combinational). During stall the in-flight address is re-read, so `imem_rdata` always corresponds to `req_pc`.
- IDLE/DONE:
  - `req_v` = `ir_v` = 0.
  - On `start`: `fpc` <= `start_addr`, enter RUN. `done` clears on leaving DONE.
- RUN, `stall` = 0, no redirect/halt:
  - `req_v` <= 1, `req_pc` <= `fpc`, `fpc` <= `fpc` + 1 (mod 2^PC_W).
  - IR <= `imem_rdata`, `ir_pc` <= `req_pc`, `ir_v` <= `req_v`.
- RUN, `stall` = 1: every register holds. `redirect` and `halt` are ignored.
- Redirect (RUN, `ir_v` = 1, `stall` = 0, `redirect` = 1):
  - `fpc` <= `target`.
  - `req_v` <= 0 and `ir_v` <= 0, killing the sequential request and IR.
- Halt (RUN, `ir_v` = 1, `stall` = 0, `halt` = 1):
  - Enter DONE, `req_v` <= 0, `ir_v` <= 0, `fpc` holds.
  - `halt` has priority over a simultaneous `redirect`.
- `redirect`/`halt` with `ir_v` = 0 are ignored.
- `start` in RUN is ignored.
- Reset (any time, including mid-run): state IDLE, `fpc` = 0, `req_pc` = 0, `req_v` = 0, IR = 0, `ir_pc` = 0, `ir_v` = 0, `done` = 0. Outputs reflect this immediately on `Reset_n` low.

## Timing
- `start` at cycle t:
  - t+1: RUN, `imem_addr` = `start_addr`.
  - t+2: `imem_rdata` = mem[`start_addr`].
  - t+3: `Instruction` = mem[`start_addr`], `instr_valid` = 1.
- Steady state: one instruction per cycle; `instr_pc` increments by 1 each unstalled cycle.
- Redirect at cycle t:
  - t+1: `imem_addr` = `target`, `instr_valid` = 0.
  - t+2: `instr_valid` = 0.
  - t+3: `Instruction` = mem[`target`], valid. Exactly 2 bubble cycles.
- Halt at cycle t: `done` = 1 and `instr_valid` = 0 from t+1. `imem_addr` stays at `fpc`.
- Stall for N cycles: `Instruction`, `instr_pc` and `instr_valid` are unchanged for those N cycles. No instruction is lost or duplicated after release.
- Wrap: `fpc` = 2^PC_W − 1 is followed by 0.

## Test plan
- Reset then `start` with `start_addr` = 5, ROM mem[i] = i: `instr_valid` rises 3 cycles later; `Instruction`/`instr_pc` sequence is 5, 6, 7, 8 on consecutive cycles.
- `stall` for 3 cycles while IR = 7: IR, `instr_pc` = 7 and `instr_valid` are held; after release the sequence continues 8, 9 with no gap or duplicate.
- `redirect` with `target` = 100 while IR holds 9: next two cycles `instr_valid` = 0, then 100, 101. Instruction 10 never appears valid.
- `redirect` asserted together with `stall`: ignored. Asserted again after stall drops: taken, with the same 2-bubble timing.
- `halt` on IR = 12: `done` = 1 and `instr_valid` = 0 next cycle and stay there. A later `start` with `start_addr` = 0 restarts the fetch stream at 0.
- `start_addr` = 1022, PC_W = 10: sequence 1022, 1023, 0, 1. `Reset_n` pulsed low mid-run: all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, synchronous ROM addressing, and the instruction register (IR) feeding the decoder.
// Latency: start or redirect -> first valid IR after 3 cycles (2 bubbles); 1 instruction/cycle in steady state.
// Backpressure: stall freezes every register and re-presents req_pc to the ROM, so the read data stays aligned.
//
// Ports:
//   CLK, Reset_n            clock, asynchronous active-low reset
//   start, start_addr       begin fetching at start_addr (accepted in IDLE/DONE only)
//   stall                   downstream not ready; hold IR and instr_valid
//   redirect, target        taken jump for the instruction currently in IR
//   halt                    instruction currently in IR is the halt instruction
//   imem_addr, imem_rdata   ROM read port (data returns one cycle after the address)
//   Instruction, instr_valid, instr_pc   IR contents, its valid flag and its address
//   done                    high while halted
module instr_fetch #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
) (
    input  logic               CLK,
    input  logic               Reset_n,
    input  logic               start,
    input  logic [PC_W-1:0]    start_addr,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    target,
    input  logic               halt,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] Instruction,
    output logic               instr_valid,
    output logic [PC_W-1:0]    instr_pc,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [PC_W-1:0]    fpc;      // next address to fetch
    logic               req_v;    // a ROM read for req_pc is in flight
    logic [PC_W-1:0]    req_pc;
    logic [INSTR_W-1:0] ir;
    logic               ir_v;
    logic [PC_W-1:0]    ir_pc;
    logic               done_r;

    // While stalled the in-flight address is re-read, so imem_rdata always
    // belongs to req_pc when the stall releases.
    assign imem_addr   = stall ? req_pc : fpc;
    assign Instruction = ir;
    assign instr_valid = ir_v;
    assign instr_pc    = ir_pc;
    assign done        = done_r;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            fpc    <= '0;
            req_v  <= 1'b0;
            req_pc <= '0;
            ir     <= '0;
            ir_v   <= 1'b0;
            ir_pc  <= '0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    req_v <= 1'b0;
                    ir_v  <= 1'b0;
                    if (start) begin
                        fpc    <= start_addr;
                        state  <= RUN;
                        done_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (ir_v && halt) begin
                            // halt wins over a simultaneous redirect; fpc is left as is
                            state  <= DONE;
                            done_r <= 1'b1;
                            req_v  <= 1'b0;
                            ir_v   <= 1'b0;
                        end else if (ir_v && redirect) begin
                            // squash the sequential request and the IR: two bubbles follow
                            fpc   <= target;
                            req_v <= 1'b0;
                            ir_v  <= 1'b0;
                        end else begin
                            req_v  <= 1'b1;
                            req_pc <= fpc;
                            fpc    <= fpc + PC_W'(1);
                            ir     <= imem_rdata;
                            ir_pc  <= req_pc;
                            ir_v   <= req_v;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus a randomized run against a stream-level model.
// Latency: n/a (bench).
// Backpressure: stall driven by directed tasks and randomly.
module tb_instr_fetch;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int DEPTH   = 1 << PC_W;

    logic               CLK;
    logic               Reset_n;
    logic               start;
    logic [PC_W-1:0]    start_addr;
    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    target;
    logic               halt;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] Instruction;
    logic               instr_valid;
    logic [PC_W-1:0]    instr_pc;
    logic               done;

    int checks = 0;
    int errors = 0;

    logic [INSTR_W-1:0] mem [DEPTH];

    instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .CLK         (CLK),
        .Reset_n     (Reset_n),
        .start       (start),
        .start_addr  (start_addr),
        .stall       (stall),
        .redirect    (redirect),
        .target      (target),
        .halt        (halt),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .Instruction (Instruction),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc),
        .done        (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // synchronous ROM: data one cycle after the address
    always @(posedge CLK) imem_rdata <= mem[imem_addr];

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic load_identity_rom;
        for (int i = 0; i < DEPTH; i++) mem[i] = INSTR_W'(i);
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; start = 0; start_addr = '0; stall = 0;
        redirect = 0; target = '0; halt = 0;
        #3;
        checks++; if (Instruction !== '0) begin errors++; $display("FAIL reset_instr got %0d exp 0", Instruction); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", instr_valid); end
        checks++; if (instr_pc !== '0) begin errors++; $display("FAIL reset_pc got %0d exp 0", instr_pc); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (imem_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d exp 0", imem_addr); end
        tick; tick;
        Reset_n = 1'b1;
        tick; tick;
        checks++; if (instr_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_quiet got valid %0b done %0b exp 0 0", instr_valid, done); end
    endtask

    task automatic test_start;
        start_addr = 10'd5; start = 1;
        tick;
        start = 0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL start_t1_valid got %0b exp 0", instr_valid); end
        checks++; if (imem_addr !== 10'd5) begin errors++; $display("FAIL start_t1_addr got %0d exp 5", imem_addr); end
        tick;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL start_t2_valid got %0b exp 0", instr_valid); end
        tick;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== PC_W'(5 + k) || Instruction !== INSTR_W'(5 + k)) begin
                errors++;
                $display("FAIL start_seq got v%0b pc %0d ins %0d exp v1 pc %0d ins %0d", instr_valid, instr_pc, Instruction, 5 + k, 5 + k);
            end
            if (k < 2) tick;
        end
    endtask

    // entered with IR = 7
    task automatic test_stall;
        for (int k = 0; k < 3; k++) begin
            stall = 1;
            tick;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 10'd7 || Instruction !== 9'd7 || imem_addr !== 10'd8) begin
                errors++;
                $display("FAIL stall_hold got v%0b pc %0d ins %0d addr %0d exp v1 pc 7 ins 7 addr 8", instr_valid, instr_pc, Instruction, imem_addr);
            end
        end
        stall = 0;
        for (int k = 8; k < 10; k++) begin
            tick;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== PC_W'(k) || Instruction !== INSTR_W'(k)) begin
                errors++;
                $display("FAIL stall_release got v%0b pc %0d ins %0d exp pc %0d", instr_valid, instr_pc, Instruction, k);
            end
        end
    endtask

    // entered with IR = 9
    task automatic test_redirect;
        redirect = 1; target = 10'd100;
        tick;
        redirect = 0;
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 10'd100) begin errors++; $display("FAIL redir_t1 got v%0b addr %0d exp v0 addr 100", instr_valid, imem_addr); end
        tick;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_t2 got v%0b exp 0", instr_valid); end
        for (int k = 100; k < 102; k++) begin
            tick;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== PC_W'(k) || Instruction !== INSTR_W'(k)) begin
                errors++;
                $display("FAIL redir_seq got v%0b pc %0d ins %0d exp pc %0d", instr_valid, instr_pc, Instruction, k);
            end
        end
    endtask

    // entered with IR = 101
    task automatic test_redirect_stall;
        redirect = 1; target = 10'd200; stall = 1;
        tick;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'd101) begin errors++; $display("FAIL redir_stall_ignored got v%0b pc %0d exp v1 pc 101", instr_valid, instr_pc); end
        stall = 0;
        tick;
        redirect = 0;
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 10'd200) begin errors++; $display("FAIL redir_after_stall got v%0b addr %0d exp v0 addr 200", instr_valid, imem_addr); end
        tick;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_after_stall_t2 got v%0b exp 0", instr_valid); end
        tick;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'd200 || Instruction !== 9'd200) begin errors++; $display("FAIL redir_after_stall_t3 got v%0b pc %0d exp v1 pc 200", instr_valid, instr_pc); end
    endtask

    task automatic test_halt;
        redirect = 1; target = 10'd11;
        tick;
        redirect = 0;
        tick; tick; tick;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 10'd12 || Instruction !== 9'd12) begin errors++; $display("FAIL halt_setup got v%0b pc %0d exp v1 pc 12", instr_valid, instr_pc); end
        halt = 1;
        tick;
        halt = 0;
        checks++; if (done !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 10'd14) begin errors++; $display("FAIL halt_t1 got done %0b v%0b addr %0d exp done 1 v0 addr 14", done, instr_valid, imem_addr); end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (done !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_stay got done %0b v%0b exp 1 0", done, instr_valid); end
        end
        start_addr = 10'd0; start = 1;
        tick;
        start = 0;
        checks++; if (done !== 1'b0 || imem_addr !== 10'd0) begin errors++; $display("FAIL restart_t1 got done %0b addr %0d exp 0 0", done, imem_addr); end
        tick; tick;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== PC_W'(k) || Instruction !== INSTR_W'(k)) begin
                errors++;
                $display("FAIL restart_seq got v%0b pc %0d exp pc %0d", instr_valid, instr_pc, k);
            end
            tick;
        end
    endtask

    task automatic test_wrap_and_reset;
        logic [PC_W-1:0] seq [4];
        seq[0] = 10'd1022; seq[1] = 10'd1023; seq[2] = 10'd0; seq[3] = 10'd1;
        Reset_n = 0;
        tick;
        Reset_n = 1;
        tick;
        start_addr = 10'd1022; start = 1;
        tick;
        start = 0;
        tick; tick;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== seq[k] || Instruction !== INSTR_W'(seq[k])) begin
                errors++;
                $display("FAIL wrap_seq got v%0b pc %0d ins %0d exp pc %0d ins %0d", instr_valid, instr_pc, Instruction, seq[k], INSTR_W'(seq[k]));
            end
            // a start while running must not disturb the stream
            start = (k == 1); start_addr = 10'd500;
            tick;
        end
        start = 0;
        #2;
        Reset_n = 0;
        #1;
        checks++;
        if (Instruction !== '0 || instr_valid !== 1'b0 || instr_pc !== '0 || done !== 1'b0 || imem_addr !== '0) begin
            errors++;
            $display("FAIL midrun_reset got ins %0d v%0b pc %0d done %0b addr %0d exp all 0", Instruction, instr_valid, instr_pc, done, imem_addr);
        end
        tick;
        Reset_n = 1;
        tick; tick; tick;
        checks++; if (instr_valid !== 1'b0 || done !== 1'b0 || imem_addr !== '0) begin errors++; $display("FAIL after_reset_idle got v%0b done %0b addr %0d exp 0 0 0", instr_valid, done, imem_addr); end
    endtask

    // Stream model: valid instructions must be mem[pc] with pc following start/redirect targets
    // and +1 otherwise, exactly 2 unstalled bubbles after each start/redirect, stalls freeze the IR.
    task automatic test_random;
        int mode, p_mode, gap;
        logic [PC_W-1:0]    exp_pc;
        logic               p_start, p_stall, p_redirect, p_halt, p_valid;
        logic [PC_W-1:0]    p_saddr, p_target, p_pc;
        logic [INSTR_W-1:0] p_instr;
        for (int i = 0; i < DEPTH; i++) mem[i] = INSTR_W'($urandom);
        start = 0; stall = 0; redirect = 0; halt = 0;
        Reset_n = 0;
        tick;
        Reset_n = 1;
        tick;
        mode = 0; p_mode = 0; gap = 0; exp_pc = '0;
        p_start = 0; p_stall = 0; p_redirect = 0; p_halt = 0; p_valid = 0;
        p_saddr = '0; p_target = '0; p_pc = '0; p_instr = '0;
        for (int n = 0; n < 1500; n++) begin
            if (mode != 1) begin
                if (p_start) begin mode = 1; exp_pc = p_saddr; gap = 0; end
            end else if (!p_stall && p_valid) begin
                if (p_halt) mode = 2;
                else if (p_redirect) begin exp_pc = p_target; gap = 0; end
                else exp_pc = exp_pc + PC_W'(1);
            end

            stall      = ($urandom % 4) == 0;
            redirect   = ($urandom % 10) == 0;
            halt       = ($urandom % 40) == 0;
            target     = PC_W'($urandom);
            start_addr = PC_W'($urandom);
            start      = (mode != 1) ? (($urandom % 3) == 0) : (($urandom % 25) == 0);

            checks++; if (done !== (mode == 2)) begin errors++; $display("FAIL rnd_done cyc %0d got %0b exp %0b", n, done, mode == 2); end
            if (mode != 1) begin
                checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rnd_idle_valid cyc %0d got %0b exp 0", n, instr_valid); end
            end else begin
                if (p_mode == 1 && p_stall) begin
                    checks++;
                    if (instr_valid !== p_valid || instr_pc !== p_pc || Instruction !== p_instr) begin
                        errors++;
                        $display("FAIL rnd_stall_hold cyc %0d got v%0b pc %0d ins %0d exp v%0b pc %0d ins %0d", n, instr_valid, instr_pc, Instruction, p_valid, p_pc, p_instr);
                    end
                end
                if (instr_valid === 1'b1) begin
                    checks++;
                    if (instr_pc !== exp_pc || Instruction !== mem[exp_pc] || gap != 2) begin
                        errors++;
                        $display("FAIL rnd_stream cyc %0d got pc %0d ins %0d bubbles %0d exp pc %0d ins %0d bubbles 2", n, instr_pc, Instruction, gap, exp_pc, mem[exp_pc]);
                    end
                end else if (!stall) begin
                    gap++;
                    checks++; if (gap > 2) begin errors++; $display("FAIL rnd_bubbles cyc %0d got %0d exp <=2", n, gap); end
                end
            end

            p_mode = mode; p_start = start; p_stall = stall; p_redirect = redirect; p_halt = halt;
            p_saddr = start_addr; p_target = target;
            p_valid = instr_valid; p_pc = instr_pc; p_instr = Instruction;
            tick;
        end
        start = 0; stall = 0; redirect = 0; halt = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        load_identity_rom();
        test_reset();
        test_start();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_halt();
        test_wrap_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
